count_checker: RTL and testbench

Sequence checker for the free-running counters in this codebase. It samples a WIDTH-bit count stream and verifies that each sample equals the previous sample plus one, modulo 2^WIDTH. It acquires lock after a run of correct steps, then flags and counts every break in the sequence. It sits on the receiving side of a counter, either in simulation benches or as an on-chip health monitor.

---
 rtl/count_checker.sv | 108 ++++++++++
 tb/tb_count_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// Sequence checker for free-running counters: locks onto a +1 (mod 2^WIDTH)
// count stream, then flags, counts and resynchronises on every break.
module count_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 error,
  output logic                 wrap,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t               state_reg;
  logic [GW-1:0]        good_run_reg;
  logic [WIDTH-1:0]     expected_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;
  logic [ERR_CNT_W-1:0] err_count_next;
  logic                 locked_reg;
  logic                 error_reg;
  logic                 wrap_reg;

  logic                 match;
  logic                 break_seen;
  logic [GW-1:0]        good_run_inc;

  always_comb begin
    match        = (count == expected_reg);
    break_seen   = enable && (state_reg == LOCKED) && !match;
    good_run_inc = good_run_reg + GW'(1);
    // A clear on the same edge as a break keeps that break in the count.
    err_count_next = err_count_reg;
    if (clear_err)
      err_count_next = break_seen ? ERR_CNT_W'(1) : '0;
    else if (break_seen && !(&err_count_reg))
      err_count_next = err_count_reg + ERR_CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      good_run_reg  <= '0;
      expected_reg  <= '0;
      err_count_reg <= '0;
      locked_reg    <= 1'b0;
      error_reg     <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      error_reg     <= 1'b0;
      wrap_reg      <= 1'b0;
      err_count_reg <= err_count_next;
      if (enable) begin
        // Always resynchronise to the observed value, not the old prediction.
        expected_reg <= count + WIDTH'(1);
        case (state_reg)
          IDLE: begin
            good_run_reg <= '0;
            state_reg    <= ACQUIRE;
            locked_reg   <= 1'b0;
          end
          ACQUIRE: begin
            if (match) begin
              good_run_reg <= good_run_inc;
              if (good_run_inc == GW'(LOCK_COUNT)) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
              end
            end else begin
              good_run_reg <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap_reg <= (count == '0);
            end else begin
              error_reg    <= 1'b1;
              good_run_reg <= '0;
              state_reg    <= ACQUIRE;
              locked_reg   <= 1'b0;
            end
          end
          default: begin
            state_reg    <= IDLE;
            good_run_reg <= '0;
            locked_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_reg;
  assign error     = error_reg;
  assign wrap      = wrap_reg;
  assign expected  = expected_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker (WIDTH=4, LOCK_COUNT=2, ERR_CNT_W=2).
module tb_count_checker;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] count;
  logic       clear_err;
  logic       locked;
  logic       error;
  logic       wrap;
  logic [3:0] expected;
  logic [1:0] err_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] v;
  logic [3:0] nxt;

  count_checker #(.WIDTH(4), .LOCK_COUNT(2), .ERR_CNT_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .count     (count),
    .clear_err (clear_err),
    .locked    (locked),
    .error     (error),
    .wrap      (wrap),
    .expected  (expected),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step(input logic en, input logic [3:0] c);
    enable = en;
    count  = c;
    @(posedge clock);
    #1;
  endtask

  // Break a locked stream at nxt+5, optionally add a silent ACQUIRE mismatch,
  // then relock with two correct steps.
  task automatic brk(input int exp_err, input logic glitch, input logic clr);
    logic [3:0] c;
    logic [3:0] r;
    c = nxt + 4'd5;
    clear_err = clr;
    step(1'b1, c);
    clear_err = 1'b0;
    chk("brk_error", int'(error), 1);
    chk("brk_locked", int'(locked), 0);
    chk("brk_expected", int'(expected), int'(c + 4'd1));
    chk("brk_err_count", int'(err_count), exp_err);
    r = c + 4'd1;
    if (glitch) begin
      step(1'b1, c + 4'd7);
      chk("acq_mismatch_error", int'(error), 0);
      chk("acq_mismatch_err_count", int'(err_count), exp_err);
      r = c + 4'd8;
    end
    step(1'b1, r);
    chk("relock1_locked", int'(locked), 0);
    step(1'b1, r + 4'd1);
    chk("relock2_locked", int'(locked), 1);
    nxt = r + 4'd2;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    count     = 4'd0;
    clear_err = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_expected", int'(expected), 0);
    chk("rst_err_count", int'(err_count), 0);
    reset = 1'b0;

    // Lock-in
    step(1'b1, 4'd0);
    chk("lock_s0_locked", int'(locked), 0);
    chk("lock_s0_expected", int'(expected), 1);
    step(1'b1, 4'd1);
    chk("lock_s1_locked", int'(locked), 0);
    step(1'b1, 4'd2);
    chk("lock_s2_locked", int'(locked), 1);
    chk("lock_s2_expected", int'(expected), 3);
    chk("lock_s2_error", int'(error), 0);

    // Wrap
    for (int i = 3; i <= 13; i++) step(1'b1, 4'(i));
    step(1'b1, 4'd14);
    chk("wrap_14", int'(wrap), 0);
    step(1'b1, 4'd15);
    chk("wrap_15", int'(wrap), 0);
    chk("wrap_15_expected", int'(expected), 0);
    step(1'b1, 4'd0);
    chk("wrap_0", int'(wrap), 1);
    chk("wrap_0_error", int'(error), 0);
    chk("wrap_0_locked", int'(locked), 1);
    step(1'b1, 4'd1);
    chk("wrap_1", int'(wrap), 0);

    // Break and relock
    for (int i = 2; i <= 6; i++) step(1'b1, 4'(i));
    step(1'b1, 4'd9);
    chk("break_error", int'(error), 1);
    chk("break_locked", int'(locked), 0);
    chk("break_err_count", int'(err_count), 1);
    chk("break_expected", int'(expected), 10);
    step(1'b1, 4'd10);
    chk("break_10_error", int'(error), 0);
    chk("break_10_locked", int'(locked), 0);
    step(1'b1, 4'd11);
    chk("break_11_locked", int'(locked), 1);

    // Enable gaps
    v = 4'd12;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, v);
      v = v + 4'd1;
    end
    chk("gap_pre_expected", int'(expected), 7);
    step(1'b0, 4'd7);
    step(1'b0, 4'd8);
    step(1'b0, 4'd9);
    chk("gap_hold_expected", int'(expected), 7);
    chk("gap_hold_locked", int'(locked), 1);
    step(1'b1, 4'd7);
    chk("gap_error", int'(error), 0);
    chk("gap_locked", int'(locked), 1);
    chk("gap_expected", int'(expected), 8);
    nxt = 4'd8;

    // Second break, then async reset between edges
    brk(2, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("areset_locked", int'(locked), 0);
    chk("areset_error", int'(error), 0);
    chk("areset_wrap", int'(wrap), 0);
    chk("areset_expected", int'(expected), 0);
    chk("areset_err_count", int'(err_count), 0);
    #1 reset = 1'b0;
    step(1'b1, 4'd3);
    chk("relock_a_locked", int'(locked), 0);
    step(1'b1, 4'd4);
    chk("relock_b_locked", int'(locked), 0);
    step(1'b1, 4'd5);
    chk("relock_c_locked", int'(locked), 1);
    nxt = 4'd6;

    // Saturation and clear
    brk(1, 1'b1, 1'b0);
    brk(2, 1'b0, 1'b0);
    brk(3, 1'b0, 1'b0);
    brk(3, 1'b0, 1'b0);
    brk(3, 1'b0, 1'b0);
    brk(1, 1'b0, 1'b1);
    clear_err = 1'b1;
    step(1'b0, 4'd0);
    clear_err = 1'b0;
    chk("clear_only_err_count", int'(err_count), 0);
    chk("clear_only_locked", int'(locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
